// File: rtl/recip_nr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : recip_nr_unit
//  Description : Reciprocal-approximation mantissa unit. A normalised divisor
//                mantissa d (0.1xxx) indexes an elaboration-time seed table
//                to give x0 = 1.seed. ITER Newton-Raphson steps then run on
//                one shared, registered multiplier:
//                    t = d*x ;  x = x*(2 - t)
//                The result is y = round-half-up(x * 2^(MANT_W-1)),
//                saturated to all ones.
//  Ports       : clk, rst        clock / asynchronous active-high reset
//                in_valid/ready  operand handshake (ready only when idle)
//                in_mant, in_tag divisor mantissa and opaque tag
//                out_valid/ready result handshake (held until accepted)
//                out_mant        reciprocal mantissa
//                out_err         input was not normalised (MSB = 0)
//                out_tag         tag of this result
//  Revision    : 1.0 - initial release
// ============================================================================
module recip_nr_unit #(
    parameter int MANT_W   = 48,
    parameter int SEED_IN  = 7,
    parameter int SEED_OUT = 4,
    parameter int ITER     = 3,
    parameter int GUARD    = 4,
    parameter int TAG_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_err,
    output logic [TAG_W-1:0]  out_tag
);

    // Internal fixed point: 2 integer bits, F fraction bits.
    localparam int F     = MANT_W + GUARD;
    localparam int XW    = F + 2;
    localparam int PW    = 2 * XW;
    localparam int IW    = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int ROM_N = 2 ** SEED_IN;

    generate
        if (SEED_IN > MANT_W - 1) begin : g_chk_seed_in
            $error("recip_nr_unit: SEED_IN must be <= MANT_W-1");
        end
        if (SEED_OUT < 1 || SEED_OUT >= F) begin : g_chk_seed_out
            $error("recip_nr_unit: SEED_OUT must be >= 1 and below the fraction width");
        end
        if (GUARD < 2) begin : g_chk_guard
            $error("recip_nr_unit: GUARD must be >= 2");
        end
    endgenerate

    // seed[i] = clamp(round(2^(SI+SO+1) / (2^SI + i + 0.5)) - 2^SO, 0, 2^SO-1)
    // The half-offset divisor is doubled out so the whole thing stays integer:
    // round(2N / (2D+1)) = floor((4N + 2D + 1) / (4D + 2)).
    function automatic logic [ROM_N*SEED_OUT-1:0] build_seed_rom();
        logic [ROM_N*SEED_OUT-1:0] rom;
        longint num;
        longint den;
        longint q;
        rom = '0;
        num = longint'(1) << (SEED_IN + SEED_OUT + 1);
        for (int i = 0; i < ROM_N; i++) begin
            den = (longint'(1) << SEED_IN) + longint'(i);
            q   = (4 * num + 2 * den + 1) / (4 * den + 2);
            q   = q - (longint'(1) << SEED_OUT);
            if (q < 0) begin
                q = 0;
            end
            if (q > (longint'(1) << SEED_OUT) - 1) begin
                q = (longint'(1) << SEED_OUT) - 1;
            end
            rom[i*SEED_OUT +: SEED_OUT] = q[SEED_OUT-1:0];
        end
        return rom;
    endfunction

    localparam logic [ROM_N*SEED_OUT-1:0] SEED_ROM = build_seed_rom();

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEED = 3'd1,
        S_MULA = 3'd2,
        S_MULB = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [MANT_W-1:0] r_d;
    logic [TAG_W-1:0]  r_tag;
    logic              r_err;
    logic [XW-1:0]     r_x;
    logic [XW-1:0]     r_t;
    logic [IW-1:0]     r_iter;

    logic [SEED_IN-1:0]  w_idx;
    logic [SEED_OUT-1:0] w_seed;
    logic [XW-1:0]       w_x0;
    logic [XW-1:0]       w_d_fx;
    logic [XW-1:0]       w_two_m_t;
    logic [XW-1:0]       w_op_a;
    logic [XW-1:0]       w_op_b;
    logic [PW-1:0]       w_prod;
    logic [XW-1:0]       w_prod_fx;
    logic [XW:0]         w_rnd;
    logic [MANT_W+1:0]   w_y_full;
    logic [MANT_W-1:0]   w_y;
    logic                w_unused;

    assign w_idx  = r_d[MANT_W-2 -: SEED_IN];
    assign w_seed = SEED_ROM[w_idx*SEED_OUT +: SEED_OUT];
    assign w_x0   = {2'b01, w_seed, {(F-SEED_OUT){1'b0}}};

    // d aligned to the same F-fraction format so both multiplier uses share
    // one product shift.
    assign w_d_fx    = {2'b00, r_d, {GUARD{1'b0}}};
    assign w_two_m_t = {2'b10, {F{1'b0}}} - r_t;

    // Shared multiplier: d*x in MULA, x*(2-t) in MULB; result truncated to F
    // fraction bits. Both products stay below 4, so the top bits are zero.
    assign w_op_a    = (r_state == S_MULA) ? w_d_fx : r_x;
    assign w_op_b    = (r_state == S_MULA) ? r_x    : w_two_m_t;
    assign w_prod    = {{XW{1'b0}}, w_op_a} * {{XW{1'b0}}, w_op_b};
    assign w_prod_fx = w_prod[F +: XW];

    // y = round-half-up(x * 2^(MANT_W-1)); anything reaching 2^MANT_W
    // (d = 0.5 exactly) saturates to all ones.
    assign w_rnd    = {1'b0, r_x} + {{(XW-GUARD){1'b0}}, 1'b1, {GUARD{1'b0}}};
    assign w_y_full = w_rnd[XW:GUARD+1];
    assign w_y      = (|w_y_full[MANT_W+1:MANT_W]) ? {MANT_W{1'b1}}
                                                   : w_y_full[MANT_W-1:0];

    assign w_unused = ^{w_prod[PW-1:F+XW], w_prod[F-1:0], w_rnd[GUARD:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_d     <= '0;
            r_tag   <= '0;
            r_err   <= 1'b0;
            r_x     <= '0;
            r_t     <= '0;
            r_iter  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_d    <= in_mant;
                        r_tag  <= in_tag;
                        r_err  <= ~in_mant[MANT_W-1];
                        r_iter <= '0;
                    end
                end
                S_SEED: r_x <= w_x0;
                S_MULA: r_t <= w_prod_fx;
                S_MULB: begin
                    r_x    <= w_prod_fx;
                    r_iter <= r_iter + IW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = in_mant[MANT_W-1] ? S_SEED : S_DONE;
                end
            end
            S_SEED:  w_state_nxt = (ITER == 0) ? S_DONE : S_MULA;
            S_MULA:  w_state_nxt = S_MULB;
            S_MULB:  w_state_nxt = (r_iter == IW'(ITER - 1)) ? S_DONE : S_MULA;
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_err   = out_valid & r_err;
    assign out_mant  = (out_valid && !r_err) ? w_y : '0;
    assign out_tag   = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_recip_nr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_recip_nr_unit
//  Description : Self-checking bench for recip_nr_unit. A 16-bit instance
//                (ITER=3) covers reset, latency, error path, back-pressure,
//                back-to-back and a random sweep; a 48-bit instance (ITER=4)
//                gets a random sweep. Results are judged against the exact
//                reciprocal 2^(2W-1)/d with a 2 ULP tolerance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_recip_nr_unit;

    localparam int W  = 16;
    localparam int WW = 48;
    localparam int TW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, out_valid, out_ready, out_err;
    logic [W-1:0]  in_mant, out_mant;
    logic [TW-1:0] in_tag, out_tag;

    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [WW-1:0] b_in_mant, b_out_mant;
    logic [TW-1:0] b_in_tag, b_out_tag;

    int checks = 0;
    int errors = 0;

    recip_nr_unit #(.MANT_W(W), .SEED_IN(7), .SEED_OUT(4), .ITER(3), .GUARD(4), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mant(in_mant), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant),
        .out_err(out_err), .out_tag(out_tag)
    );

    recip_nr_unit #(.MANT_W(WW), .SEED_IN(7), .SEED_OUT(4), .ITER(4), .GUARD(4), .TAG_W(TW)) dut_wide (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mant(b_in_mant), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_mant(b_out_mant),
        .out_err(b_out_err), .out_tag(b_out_tag)
    );

    // Reference: exact reciprocal is 2^31/d; |y - 2^31/d| <= 2  <=>  |y*d - 2^31| <= 2d
    function automatic bit ok16(input logic [W-1:0] y, input logic [W-1:0] d);
        longint p;
        longint diff;
        p    = longint'(y) * longint'(d);
        diff = p - (longint'(1) << 31);
        if (diff < 0) diff = -diff;
        return diff <= 2 * longint'(d);
    endfunction

    function automatic bit ok48(input logic [WW-1:0] y, input logic [WW-1:0] d);
        logic [127:0] p, tgt, diff;
        p    = {80'd0, y} * {80'd0, d};
        tgt  = 128'd1 << 95;
        diff = (p > tgt) ? p - tgt : tgt - p;
        return diff <= {79'd0, d, 1'b0};
    endfunction

    // Stimulus helper: present one operand, wait for the result (bounded) and
    // leave it pending in the unit. lat counts clock edges from the accepting
    // edge (inclusive) to the first cycle with out_valid.
    task automatic run_op(input logic [W-1:0] d, input logic [TW-1:0] tag, output int lat,
                          output logic [W-1:0] y, output logic e, output logic [TW-1:0] ot);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        in_mant  = d;
        in_tag   = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mant  = W'($urandom);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        y  = out_mant;
        e  = out_err;
        ot = out_tag;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
        checks++; if (out_mant !== '0) begin errors++; $display("FAIL reset_out_mant: got %h expected 0", out_mant); end
        checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_half();
        int lat; logic [W-1:0] y; logic e; logic [TW-1:0] ot;
        run_op(16'h8000, 8'h5A, lat, y, e, ot);
        checks++; if (lat !== 8) begin errors++; $display("FAIL half_latency: got %0d expected 8", lat); end
        checks++; if (y !== 16'hFFFF) begin errors++; $display("FAIL half_mant: got %h expected ffff", y); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL half_err: got %b expected 0", e); end
        checks++; if (ot !== 8'h5A) begin errors++; $display("FAIL half_tag: got %h expected 5a", ot); end
        consume();
    endtask

    task automatic test_known();
        int lat; logic [W-1:0] y; logic e; logic [TW-1:0] ot;
        run_op(16'hC000, 8'h11, lat, y, e, ot);
        checks++; if (lat !== 8) begin errors++; $display("FAIL c000_latency: got %0d expected 8", lat); end
        checks++; if (y < 16'hAAA9 || y > 16'hAAAC) begin errors++; $display("FAIL c000_mant: got %h expected aaa9..aaac", y); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL c000_err: got %b expected 0", e); end
        consume();
        run_op(16'hFFFF, 8'h22, lat, y, e, ot);
        checks++; if (y < 16'h8000 || y > 16'h8002) begin errors++; $display("FAIL ffff_mant: got %h expected 8000..8002", y); end
        checks++; if (ot !== 8'h22) begin errors++; $display("FAIL ffff_tag: got %h expected 22", ot); end
        consume();
    endtask

    task automatic test_err();
        int lat; logic [W-1:0] y; logic e; logic [TW-1:0] ot;
        logic [W-1:0] bad [2];
        bad[0] = 16'h0000;
        bad[1] = 16'h7FFF;
        for (int k = 0; k < 2; k++) begin
            run_op(bad[k], 8'(8'hE0 + k), lat, y, e, ot);
            checks++; if (lat !== 1) begin errors++; $display("FAIL err_latency d=%h: got %0d expected 1", bad[k], lat); end
            checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_flag d=%h: got %b expected 1", bad[k], e); end
            checks++; if (y !== '0) begin errors++; $display("FAIL err_mant d=%h: got %h expected 0", bad[k], y); end
            checks++; if (ot !== 8'(8'hE0 + k)) begin errors++; $display("FAIL err_tag d=%h: got %h expected %h", bad[k], ot, 8'(8'hE0 + k)); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [W-1:0] y; logic e; logic [TW-1:0] ot;
        run_op(16'h9000, 8'h33, lat, y, e, ot);
        checks++; if (!ok16(y, 16'h9000)) begin errors++; $display("FAIL bp_mant: got %h expected within 2 ULP of 2^31/9000h", y); end
        // Another operand waits at the input the whole time and must not enter.
        in_valid = 1'b1;
        in_mant  = 16'hA000;
        in_tag   = 8'h77;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %b expected 1", c, out_valid); end
            checks++; if (out_mant !== y) begin errors++; $display("FAIL bp_mant_stable c%0d: got %h expected %h", c, out_mant, y); end
            checks++; if (out_tag !== 8'h33) begin errors++; $display("FAIL bp_tag_stable c%0d: got %h expected 33", c, out_tag); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d: got %b expected 0", c, in_ready); end
        end
        in_valid = 1'b0;
        consume();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [W-1:0] y; logic e; logic [TW-1:0] ot;
        run_op(16'hB000, 8'h44, lat, y, e, ot);
        // Drain and offer the next operand in the same cycle.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mant   = 16'hD123;
        in_tag    = 8'h55;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_latency: got %0d expected 8", lat); end
        checks++; if (!ok16(out_mant, 16'hD123)) begin errors++; $display("FAIL b2b_mant: got %h expected within 2 ULP of 2^31/d123h", out_mant); end
        checks++; if (out_tag !== 8'h55) begin errors++; $display("FAIL b2b_tag: got %h expected 55", out_tag); end
        consume();
    endtask

    task automatic test_reset_mid();
        int lat; logic [W-1:0] y; logic e; logic [TW-1:0] ot;
        @(negedge clk);
        in_valid = 1'b1;
        in_mant  = 16'hC000;
        in_tag   = 8'h66;
        @(posedge clk);          // accept -> SEED
        #1;
        in_valid = 1'b0;
        @(posedge clk);          // -> MULA
        @(posedge clk);          // -> MULB
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", in_ready); end
        #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stray_valid c%0d: got %b expected 0", c, out_valid); end
        end
        run_op(16'hC000, 8'h67, lat, y, e, ot);
        checks++; if (lat !== 8) begin errors++; $display("FAIL rstmid_latency: got %0d expected 8", lat); end
        checks++; if (y < 16'hAAA9 || y > 16'hAAAC) begin errors++; $display("FAIL rstmid_mant: got %h expected aaa9..aaac", y); end
        checks++; if (ot !== 8'h67) begin errors++; $display("FAIL rstmid_tag: got %h expected 67", ot); end
        consume();
    endtask

    task automatic test_random();
        int lat; logic [W-1:0] y; logic e; logic [TW-1:0] ot;
        logic [W-1:0] d;
        logic [TW-1:0] tg;
        for (int n = 0; n < 3000; n++) begin
            case (n)
                0: d = 16'h8000;
                1: d = 16'h8001;
                2: d = 16'hFFFE;
                3: d = 16'hFFFF;
                default: d = W'($urandom);
            endcase
            if (n >= 4 && ($urandom % 8) != 0) d[W-1] = 1'b1;
            tg = TW'($urandom);
            run_op(d, tg, lat, y, e, ot);
            checks++; if (ot !== tg) begin errors++; $display("FAIL rand_tag d=%h: got %h expected %h", d, ot, tg); end
            if (d[W-1]) begin
                checks++; if (lat !== 8 || e !== 1'b0) begin errors++; $display("FAIL rand_lat_err d=%h: got lat %0d err %b expected 8/0", d, lat, e); end
                checks++; if (!ok16(y, d)) begin errors++; $display("FAIL rand_mant d=%h: got %h expected within 2 ULP of 2^31/d", d, y); end
            end else begin
                checks++; if (lat !== 1 || e !== 1'b1 || y !== '0) begin errors++; $display("FAIL rand_errpath d=%h: got lat %0d err %b mant %h expected 1/1/0", d, lat, e, y); end
            end
            consume();
        end
    endtask

    task automatic test_wide();
        logic [63:0]   r;
        logic [WW-1:0] d;
        logic [TW-1:0] tg;
        int lat;
        int guard;
        for (int n = 0; n < 300; n++) begin
            r = {$urandom, $urandom};
            case (n)
                0: d = {1'b1, {(WW-1){1'b0}}};
                1: d = {WW{1'b1}};
                default: d = r[WW-1:0] | {1'b1, {(WW-1){1'b0}}};
            endcase
            tg = TW'($urandom);
            @(negedge clk);
            guard = 0;
            while (!b_in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            b_in_valid = 1'b1;
            b_in_mant  = d;
            b_in_tag   = tg;
            @(posedge clk);
            #1;
            b_in_valid = 1'b0;
            lat = 1;
            @(negedge clk);
            while (!b_out_valid && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            checks++; if (lat !== 10) begin errors++; $display("FAIL wide_latency d=%h: got %0d expected 10", d, lat); end
            checks++; if (!ok48(b_out_mant, d) || b_out_err !== 1'b0) begin errors++; $display("FAIL wide_mant d=%h: got %h err %b expected within 2 ULP of 2^95/d", d, b_out_mant, b_out_err); end
            checks++; if (b_out_tag !== tg) begin errors++; $display("FAIL wide_tag d=%h: got %h expected %h", d, b_out_tag, tg); end
            b_out_ready = 1'b1;
            @(posedge clk);
            #1;
            b_out_ready = 1'b0;
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_mant     = '0;
        in_tag      = '0;
        out_ready   = 1'b0;
        b_in_valid  = 1'b0;
        b_in_mant   = '0;
        b_in_tag    = '0;
        b_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_half();
        test_known();
        test_err();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
